instruction: RTL and testbench

INSTRUCTION -- requirements
Module: instruction

---
 rtl/instruction_if.sv | 26 ++
 rtl/instruction.sv | 96 +++++++++
 tb/tb_instruction.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/instruction_if.sv
// Decoder bus for the RV32 instruction field decoder: the word stream in, the registered decoded fields out.
// The master drives words and the slave (the decoder) returns the fields.
interface instruction_if;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_valid;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        illegal;

    modport master (
        output in_valid, instruction,
        input  out_valid, opcode, rd, funct3, rs1, rs2, funct7, fmt, imm, illegal
    );

    modport slave (
        input  in_valid, instruction,
        output out_valid, opcode, rd, funct3, rs1, rs2, funct7, fmt, imm, illegal
    );
endinterface

// File: rtl/instruction.sv
// RV32 instruction field decoder with one cycle of registered latency.
// Immediate generation is built only when INSTRUCTION_IMM_EN is defined; otherwise imm is tied to 0.
module instruction (
    input  logic         clk,
    input  logic         rst_n,
    instruction_if.slave bus
);
    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_UNK = 3'd7;

    logic        out_valid_reg;
    logic [31:0] word_reg;
    logic [2:0]  fmt_reg;
    logic [2:0]  fmt_next;
    logic        illegal_reg;
    logic        illegal_next;

    // Any opcode with [1:0] != 2'b11 falls through to the unknown format.
    always_comb begin
        fmt_next = FMT_UNK;
        case (bus.instruction[6:0])
            7'h33:                                    fmt_next = FMT_R;
            7'h03, 7'h07, 7'h0F, 7'h13, 7'h67, 7'h73: fmt_next = FMT_I;
            7'h23, 7'h27:                             fmt_next = FMT_S;
            7'h63:                                    fmt_next = FMT_B;
            7'h37, 7'h17:                             fmt_next = FMT_U;
            7'h6F:                                    fmt_next = FMT_J;
            default:                                  fmt_next = FMT_UNK;
        endcase
        illegal_next = (fmt_next == FMT_UNK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            word_reg      <= '0;
            fmt_reg       <= FMT_R;
            illegal_reg   <= 1'b0;
        end else begin
            out_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                word_reg    <= bus.instruction;
                fmt_reg     <= fmt_next;
                illegal_reg <= illegal_next;
            end
        end
    end

`ifdef INSTRUCTION_IMM_EN
    logic [31:0] imm_reg;
    logic [31:0] imm_next;
    logic [31:0] w;

    assign w = bus.instruction;

    always_comb begin
        imm_next = '0;
        case (fmt_next)
            FMT_I:   imm_next = {{20{w[31]}}, w[31:20]};
            FMT_S:   imm_next = {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:   imm_next = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FMT_U:   imm_next = {w[31:12], 12'b0};
            FMT_J:   imm_next = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: imm_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            imm_reg <= '0;
        end else if (bus.in_valid) begin
            imm_reg <= imm_next;
        end
    end

    assign bus.imm = imm_reg;
`else
    assign bus.imm = '0;
`endif

    // Field slices are taken raw from the held word, regardless of format.
    assign bus.out_valid = out_valid_reg;
    assign bus.opcode    = word_reg[6:0];
    assign bus.rd        = word_reg[11:7];
    assign bus.funct3    = word_reg[14:12];
    assign bus.rs1       = word_reg[19:15];
    assign bus.rs2       = word_reg[24:20];
    assign bus.funct7    = word_reg[31:25];
    assign bus.fmt       = fmt_reg;
    assign bus.illegal   = illegal_reg;
endmodule

// File: tb/tb_instruction.sv
// Self-checking bench for the instruction decoder: directed vectors, then random words and resets
// checked against a behavioural model of the decode rules.
module tb_instruction;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    instruction_if bus ();

    instruction dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ov;
        logic [31:0] w;
        logic [2:0]  fmt;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t exp_s;

    logic [6:0] legal_ops [13] = '{7'h33, 7'h03, 7'h07, 7'h0F, 7'h13, 7'h67, 7'h73,
                                   7'h23, 7'h27, 7'h63, 7'h37, 7'h17, 7'h6F};

    function automatic logic [2:0] fmt_of(input logic [6:0] op);
        if (op == 7'h33) return 3'd0;
        if (op inside {7'h03, 7'h07, 7'h0F, 7'h13, 7'h67, 7'h73}) return 3'd1;
        if (op inside {7'h23, 7'h27}) return 3'd2;
        if (op == 7'h63) return 3'd3;
        if (op inside {7'h37, 7'h17}) return 3'd4;
        if (op == 7'h6F) return 3'd5;
        return 3'd7;
    endfunction

    // Immediates computed arithmetically: sign part from an arithmetic shift, fields weighted by place value.
    function automatic logic [31:0] imm_of(input logic [31:0] w, input logic [2:0] f);
        logic [31:0] sgn;
        sgn = ($signed(w) >>> 31);
        case (f)
            3'd1: return $signed(w) >>> 20;
            3'd2: return (($signed(w) >>> 25) * 32) + w[11:7];
            3'd3: return sgn * 4096 + w[7] * 2048 + w[30:25] * 32 + w[11:8] * 2;
            3'd4: return w & 32'hFFFF_F000;
            3'd5: return sgn * 1048576 + w[19:12] * 4096 + w[20] * 2048 + w[30:21] * 2;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (txn %0d)", tag, obs, expv, txn);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] w);
        logic [31:0] ew;
        rst_n           = r;
        bus.in_valid    = v;
        bus.instruction = w;
        @(posedge clk);
        if (!r) begin
            exp_s = '{ov: 1'b0, w: 32'd0, fmt: 3'd0, imm: 32'd0, ill: 1'b0};
        end else if (v) begin
            exp_s.ov  = 1'b1;
            exp_s.w   = w;
            exp_s.fmt = fmt_of(w[6:0]);
`ifdef INSTRUCTION_IMM_EN
            exp_s.imm = imm_of(w, exp_s.fmt);
`else
            exp_s.imm = 32'd0;
`endif
            exp_s.ill = (exp_s.fmt == 3'd7);
        end else begin
            exp_s.ov = 1'b0;
        end
        @(negedge clk);
        ew = exp_s.w;
        chk("out_valid", 32'(bus.out_valid), 32'(exp_s.ov));
        chk("opcode",    32'(bus.opcode),    32'(ew[6:0]));
        chk("rd",        32'(bus.rd),        32'(ew[11:7]));
        chk("funct3",    32'(bus.funct3),    32'(ew[14:12]));
        chk("rs1",       32'(bus.rs1),       32'(ew[19:15]));
        chk("rs2",       32'(bus.rs2),       32'(ew[24:20]));
        chk("funct7",    32'(bus.funct7),    32'(ew[31:25]));
        chk("fmt",       32'(bus.fmt),       32'(exp_s.fmt));
        chk("imm",       bus.imm,            exp_s.imm);
        chk("illegal",   32'(bus.illegal),   32'(exp_s.ill));
        $display("txn %0d rst_n=%b in_valid=%b word=%h -> out_valid=%b fmt=%0d imm=%h illegal=%b",
                 txn, r, v, w, bus.out_valid, bus.fmt, bus.imm, bus.illegal);
        txn++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        logic        r;
        logic        v;
        rst_n           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.instruction = '0;
        exp_s = '{ov: 1'b0, w: 32'd0, fmt: 3'd0, imm: 32'd0, ill: 1'b0};

        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 32'hFE0C_0F87);
        step(1'b1, 1'b1, 32'h0020_81B3);
        step(1'b1, 1'b1, 32'hFE00_0EE3);
        step(1'b1, 1'b1, 32'h0000_0000);
        step(1'b1, 1'b1, 32'h8000_00EF);
        step(1'b1, 1'b1, 32'hFFFF_F2B7);
        step(1'b1, 1'b1, 32'hFE11_2E23);
        step(1'b1, 1'b0, 32'h1234_5678);
        step(1'b1, 1'b0, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 32'hFE0C_0F87);
        step(1'b1, 1'b0, 32'hFE0C_0F87);
        step(1'b1, 1'b1, 32'hFE0C_0F87);

        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            if ($urandom_range(3) != 0) w[6:0] = legal_ops[$urandom_range(12)];
            r = ($urandom_range(39) != 0);
            v = ($urandom_range(3) != 0);
            step(r, v, w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
